ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data RAM. It lets the core's load/store unit (port 0) and the program loader/debug port (port 1) share one RAM. It grants one requester per access with round-robin fairness and supports locked bursts with a starvation bound. It drives the RAM's MemWrite/MemRead/address/write_data and returns registered read data with a valid strobe.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/ram_arbiter_rr_pick.sv | 22 ++
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data RAM arbiter
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rtl/ram_arbiter_rr_pick.sv - two-input round-robin picker
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_any
);

    // A lone requester wins; on a tie the port that was not served last wins.
    always_comb begin
        o_any    = |i_req;
        o_winner = PORT0;
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_req[1]) begin
            o_winner = PORT1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter and sequencer for the data RAM
module ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_DEPTH = 1024,
    parameter  int MAX_BURST  = DEFAULT_MAX_BURST,
    localparam int AW         = $clog2(ADDR_DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata,
    output logic          MemWrite,
    output logic          MemRead,
    output logic [AW-1:0] address,
    output logic [31:0]   write_data,
    input  logic [31:0]   read_data
);

    localparam int             BW         = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    r_state;
    logic          r_owner;
    logic          r_last;
    logic [BW-1:0] r_burst_cnt;
    logic [31:0]   r_rdata;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic          w_winner;
    logic          w_any;
    logic          w_req_own;
    logic          w_we_own;
    logic          w_lock_own;
    logic [AW-1:0] w_addr_own;
    logic [31:0]   w_wdata_own;
    logic          w_acc;

    rr_pick u_pick (
        .i_req    ({req1, req0}),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Select the current owner's request fields.
    always_comb begin
        w_req_own   = req0;
        w_we_own    = we0;
        w_lock_own  = lock0;
        w_addr_own  = addr0;
        w_wdata_own = wdata0;
        if (r_owner == PORT1) begin
            w_req_own   = req1;
            w_we_own    = we1;
            w_lock_own  = lock1;
            w_addr_own  = addr1;
            w_wdata_own = wdata1;
        end
    end

    // A RAM access happens only in ACCESS with the owner still requesting;
    // a dropped req in a locked continuation cycle suppresses the access.
    assign w_acc = (r_state == ACCESS) && w_req_own;

    // Grant and RAM drive decode from registered state and owner inputs.
    always_comb begin
        gnt0       = w_acc && (r_owner == PORT0);
        gnt1       = w_acc && (r_owner == PORT1);
        MemWrite   = w_acc && w_we_own;
        MemRead    = w_acc && !w_we_own;
        address    = w_acc ? w_addr_own  : '0;
        write_data = w_acc ? w_wdata_own : '0;
    end

    assign rdata   = r_rdata;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

    // Arbitration FSM, burst counting and registered read return.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_owner     <= PORT0;
            r_last      <= PORT1;
            r_burst_cnt <= '0;
            r_rdata     <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_winner;
                        r_burst_cnt <= '0;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_req_own) begin
                        r_state <= IDLE;
                    end else begin
                        r_last <= r_owner;
                        if (!w_we_own) begin
                            r_rdata <= read_data;
                            if (r_owner == PORT1) begin
                                r_rvalid1 <= 1'b1;
                            end else begin
                                r_rvalid0 <= 1'b1;
                            end
                        end
                        if (w_lock_own && (r_burst_cnt < BURST_LAST)) begin
                            r_burst_cnt <= r_burst_cnt + BW'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking scoreboard bench for ram_arbiter
module tb_ram_arbiter;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, MemWrite, MemRead;
    logic [31:0]   rdata, write_data, read_data;
    logic [AW-1:0] address;

    logic [31:0]   ram    [0:1023];
    logic [31:0]   shadow [0:1023];

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   glog_port[$];
    int   glog_cyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic          op_we   [2][8];
    logic [AW-1:0] op_addr [2][8];
    logic [31:0]   op_wd   [2][8];
    logic          op_lock [2][8];
    int            op_n    [2];

    int burst_port [7] = '{1, 1, 1, 1, 0, 1, 1};
    int burst_off  [7] = '{0, 1, 2, 3, 5, 7, 8};

    ram_arbiter #(.ADDR_DEPTH(1024), .MAX_BURST(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 CLK = ~CLK;

    assign read_data = ram[address];

    always @(posedge CLK) begin
        if (MemWrite) ram[address] <= write_data;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant logging and read-return scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (gnt0 && gnt1) check("gnt_onehot", {gnt1, gnt0}, 2'b01);
        if (gnt0) begin glog_port.push_back(0); glog_cyc.push_back(cyc); end
        if (gnt1) begin glog_port.push_back(1); glog_cyc.push_back(cyc); end
        if (rvalid0) begin
            if (exp_q0.size() == 0) check("rvalid0_unexpected", 1, 0);
            else begin
                e = exp_q0.pop_front();
                check("rdata0", rdata, e.d);
                check("rvalid0_latency", cyc, e.c + 1);
            end
        end
        if (rvalid1) begin
            if (exp_q1.size() == 0) check("rvalid1_unexpected", 1, 0);
            else begin
                e = exp_q1.pop_front();
                check("rdata1", rdata, e.d);
                check("rvalid1_latency", cyc, e.c + 1);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic l);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l; end
    endtask

    task automatic set_op(input int p, input int i, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic l);
        op_we[p][i] = w; op_addr[p][i] = a; op_wd[p][i] = d; op_lock[p][i] = l;
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Reactive requester: presents each op, waits for its grant, then moves on.
    task automatic run_port(input int p, input int delay);
        logic got;
        logic g;
        repeat (delay) step();
        for (int i = 0; i < op_n[p]; i++) begin
            drive(p, 1'b1, op_we[p][i], op_addr[p][i], op_wd[p][i], op_lock[p][i]);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge CLK);
                g = (p == 0) ? gnt0 : gnt1;
                if (g) begin
                    got = 1'b1;
                    check("grant_address", address, op_addr[p][i]);
                    check("grant_memwrite", MemWrite, op_we[p][i]);
                    check("grant_memread", MemRead, !op_we[p][i]);
                    if (op_we[p][i]) shadow[op_addr[p][i]] = op_wd[p][i];
                    else push_exp(p, shadow[op_addr[p][i]], cyc);
                end
                step();
            end
            check("grant_timeout", got, 1);
        end
        drive(p, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = 32'h1000_0000 + i;
            shadow[i] = 32'h1000_0000 + i;
        end
        #1;
        // Reset state
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid", {rvalid1, rvalid0}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_memctl", {MemWrite, MemRead}, 0);
        check("rst_address", address, 0);
        check("rst_wdata", write_data, 0);
        step();
        RST = 1'b0;
        step();

        // Single write then read on port 0
        drive(0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0);
        @(negedge CLK); check("wr_idle_no_gnt", gnt0, 0);
        step();
        @(negedge CLK);
        check("wr_gnt0", gnt0, 1);
        check("wr_memwrite", MemWrite, 1);
        check("wr_memread", MemRead, 0);
        check("wr_address", address, 5);
        check("wr_data", write_data, 32'hDEADBEEF);
        shadow[5] = 32'hDEADBEEF;
        step();
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge CLK);
        check("wr_no_rvalid", rvalid0, 0);
        check("wr_idle_gap", gnt0, 0);
        step();
        drive(0, 1'b1, 1'b0, 10'd5, '0, 1'b0);
        @(negedge CLK); check("rd_idle_no_gnt", gnt0, 0);
        step();
        @(negedge CLK);
        check("rd_gnt0", gnt0, 1);
        check("rd_memread", MemRead, 1);
        push_exp(0, shadow[5], cyc);
        step();
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge CLK);
        check("rd_rvalid0", rvalid0, 1);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        step();

        // Tie after reset: port 0 first, then port 1, then port 0 again
        do_reset();
        op_n[0] = 1; set_op(0, 0, 1'b0, 10'd5, '0, 1'b0);
        op_n[1] = 1; set_op(1, 0, 1'b0, 10'd7, '0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            glog_port.delete(); glog_cyc.delete();
            fork
                run_port(0, 0);
                run_port(1, 0);
            join
            step(); step();
            check("tie_count", glog_port.size(), 2);
            if (glog_port.size() == 2) begin
                check("tie_first", glog_port[0], 0);
                check("tie_second", glog_port[1], 1);
                check("tie_gap", glog_cyc[1] - glog_cyc[0], 2);
            end
        end

        // Port 1 locked burst of six writes with port 0 pending
        op_n[1] = 6;
        for (int i = 0; i < 6; i++) set_op(1, i, 1'b1, 10'(20 + i), 32'hB000_0000 + i, i < 5);
        op_n[0] = 1; set_op(0, 0, 1'b1, 10'd30, 32'hC0C0_C0C0, 1'b0);
        glog_port.delete(); glog_cyc.delete();
        fork
            run_port(1, 0);
            run_port(0, 1);
        join
        step(); step();
        check("burst_count", glog_port.size(), 7);
        if (glog_port.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check("burst_port", glog_port[i], burst_port[i]);
                check("burst_cycle", glog_cyc[i] - glog_cyc[0], burst_off[i]);
            end
        end
        for (int i = 0; i < 6; i++) check("burst_ram", ram[20 + i], 32'hB000_0000 + i);
        check("burst_ram_p0", ram[30], 32'hC0C0_C0C0);

        // Locked read burst of three on port 0
        for (int i = 0; i < 3; i++) begin
            ram[10 + i]    = 32'h5EED_0000 + i;
            shadow[10 + i] = 32'h5EED_0000 + i;
        end
        op_n[0] = 3;
        for (int i = 0; i < 3; i++) set_op(0, i, 1'b0, 10'(10 + i), '0, i < 2);
        glog_port.delete(); glog_cyc.delete();
        run_port(0, 0);
        step(); step();
        check("rdburst_count", glog_port.size(), 3);
        if (glog_port.size() == 3) check("rdburst_span", glog_cyc[2] - glog_cyc[0], 2);
        @(negedge CLK);
        check("rdburst_hold", rdata, 32'h5EED_0002);
        check("rdburst_rvalid_low", rvalid0, 0);
        step();

        // Asynchronous reset during a write access
        ram[40] = 32'hAAAA_5555;
        drive(0, 1'b1, 1'b1, 10'd40, 32'h1234_5678, 1'b0);
        step();
        #1;
        check("rstmid_gnt_before", gnt0, 1);
        check("rstmid_wr_before", MemWrite, 1);
        #1;
        RST = 1'b1;
        #1;
        check("rstmid_gnt_drop", gnt0, 0);
        check("rstmid_wr_drop", MemWrite, 0);
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        RST = 1'b0;
        step();
        check("rstmid_ram_kept", ram[40], 32'hAAAA_5555);
        check("rstmid_gnts", {gnt1, gnt0}, 0);
        check("rstmid_rvalid", {rvalid1, rvalid0}, 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_memctl", {MemWrite, MemRead}, 0);

        // Protocol violation: req dropped in a locked continuation cycle
        drive(0, 1'b1, 1'b0, 10'd10, '0, 1'b1);
        step();
        @(negedge CLK);
        check("viol_first_gnt", gnt0, 1);
        push_exp(0, shadow[10], cyc);
        step();
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        check("viol_no_gnt", {gnt1, gnt0}, 0);
        check("viol_no_access", {MemWrite, MemRead}, 0);
        check("viol_address", address, 0);
        step();
        check("viol_state_idle", 64'(dut.r_state), 0);
        @(negedge CLK);
        check("viol_no_rvalid", rvalid0, 0);
        check("viol_idle_gnt", {gnt1, gnt0}, 0);
        step(); step();

        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
